seq_div: RTL and testbench

- Parametrised, multi-cycle integer divider with a start/done handshake.
- Generalises the fixed 4-bit combinational divide-by-3 to any operand width, any runtime divisor, and optional signed operation.
- Produces quotient, remainder and a divide-by-zero flag.
- Intended as the arithmetic unit for the lab datapaths that follow: it sits between a register file/controller and the result bus.

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_div_step.sv | 25 ++
 rtl/seq_div.sv | 147 ++++++++++++++
 tb/tb_seq_div.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared FSM encodings and constants for the sequential divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // All-ones quotient reported on divide-by-zero, right-aligned to the operand width.
    function automatic logic [31:0] dz_quotient(input int unsigned width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division step
module seq_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-2:0] quo_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < dvs keeps shifted < 2*dvs, so trial[WIDTH] is exactly the borrow.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = quo[WIDTH-2:0];
    end

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle signed/unsigned integer divider with start/done handshake
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] DZ_Q = WIDTH'(dz_quotient(WIDTH));

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-2:0] step_quo;
    logic             step_bit;
    logic [WIDTH-1:0] a_mag, b_mag;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo),
        .q_bit    (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_pend_q <= dz_pend_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_pend_d = dz_pend_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;
        // Most-negative magnitude still fits as an unsigned WIDTH-bit value.
        a_mag     = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag     = (sgn && b[WIDTH-1]) ? -b : b;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    neg_quo_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn & a[WIDTH-1];
                    if (b == '0) begin
                        dz_pend_d = 1'b1;
                        rem_d     = a;
                        state_d   = S_FIX;
                    end else begin
                        dz_pend_d = 1'b0;
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        cnt_d     = CW'(WIDTH - 1);
                        state_d   = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = {step_quo, step_bit};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                if (dz_pend_q) begin
                    q_d  = DZ_Q;
                    r_d  = rem_q;
                    dz_d = 1'b1;
                end else begin
                    q_d  = neg_quo_q ? -quo_q : quo_q;
                    r_d  = neg_rem_q ? -rem_q : rem_q;
                    dz_d = 1'b0;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_FIX);
        done = (state_q == S_DONE);
        q    = q_q;
        r    = r_q;
        dz   = dz_q;
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - scoreboard bench for seq_div at WIDTH=4 and WIDTH=8
module tb_seq_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst4, start4, sgn4, busy4, done4, dz4;
    logic [3:0] a4, b4, q4, r4;
    logic       rst8, start8, sgn8, busy8, done8, dz8;
    logic [7:0] a8, b8, q8, r8;

    seq_div #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .q(q4), .r(r4), .dz(dz4)
    );

    seq_div #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .q(q8), .r(r8), .dz(dz8)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         cyc;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed4 = 0, pushed8 = 0, seen4 = 0, seen8 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst4 && done4) begin
            seen4++;
            if (sb4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected done: q=%0d r=%0d expected no result", q4, r4);
            end else begin
                e = sb4.pop_front();
                check("dut4 q", 32'(q4), 32'(e.q[3:0]));
                check("dut4 r", 32'(r4), 32'(e.r[3:0]));
                check("dut4 dz", 32'(dz4), 32'(e.dz));
                check("dut4 done cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst8 && done8) begin
            seen8++;
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 unexpected done: q=%0d r=%0d expected no result", q8, r8);
            end else begin
                e = sb8.pop_front();
                check("dut8 q", 32'(q8), 32'(e.q));
                check("dut8 r", 32'(r8), 32'(e.r));
                check("dut8 dz", 32'(dz8), 32'(e.dz));
                check("dut8 done cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_done4();
        for (int i = 0; i < 40 && !done4; i++) @(negedge clk);
        if (!done4) begin
            checks++;
            errors++;
            $display("FAIL dut4 timeout: done=%0d expected 1", done4);
        end
    endtask

    task automatic wait_done8();
        for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
        if (!done8) begin
            checks++;
            errors++;
            $display("FAIL dut8 timeout: done=%0d expected 1", done8);
        end
    endtask

    // Caller is at a negedge; returns at the negedge where done is high.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [3:0] eq, input logic [3:0] er, input logic edz);
        exp_t e;
        a4 = a; b4 = b; sgn4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        e.q = {4'd0, eq}; e.r = {4'd0, er}; e.dz = edz;
        e.cyc = cyc + ((b == 4'd0) ? 1 : 5);
        sb4.push_back(e);
        pushed4++;
        wait_done4();
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
        exp_t e;
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        e.q = eq; e.r = er; e.dz = edz;
        e.cyc = cyc + ((b == 8'd0) ? 1 : 9);
        sb8.push_back(e);
        pushed8++;
        wait_done8();
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: cycle=%0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst4 = 1'b1; start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
        rst8 = 1'b1; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy4), 0);
        check("reset done", 32'(done4), 0);
        check("reset q", 32'(q4), 0);
        check("reset r", 32'(r4), 0);
        check("reset dz", 32'(dz4), 0);
        check("reset busy8", 32'(busy8), 0);
        rst4 = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);

        // 15/3 with cycle-by-cycle busy/done trace
        a4 = 4'd15; b4 = 4'd3; sgn4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        e.q = 8'd5; e.r = 8'd0; e.dz = 1'b0; e.cyc = cyc + 5;
        sb4.push_back(e);
        pushed4++;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("busy trace k=%0d", k), 32'(busy4), 1);
            check($sformatf("done trace k=%0d", k), 32'(done4), 0);
        end
        @(negedge clk);
        check("busy after finish", 32'(busy4), 0);
        check("done after finish", 32'(done4), 1);

        run4(4'd14, 4'd3, 1'b0, 4'd4, 4'd2, 1'b0);

        for (int i = 0; i < 16; i++)
            run4(4'(i), 4'd3, 1'b0, 4'(i / 3), 4'(i % 3), 1'b0);

        run4(4'd9, 4'd0, 1'b0, 4'b1111, 4'b1001, 1'b1);
        run4(4'd15, 4'd3, 1'b0, 4'd5, 4'd0, 1'b0);
        run4(4'd5, 4'd0, 1'b1, 4'b1111, 4'b0101, 1'b1);

        run4(4'b1001, 4'd2, 1'b1, 4'b1101, 4'b1111, 1'b0);
        run4(4'd7, 4'b1110, 1'b1, 4'b1101, 4'd1, 1'b0);
        run4(4'b1000, 4'b1111, 1'b1, 4'b1000, 4'd0, 1'b0);

        // start while busy must be ignored
        a4 = 4'd15; b4 = 4'd3; sgn4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        e.q = 8'd5; e.r = 8'd0; e.dz = 1'b0; e.cyc = cyc + 5;
        sb4.push_back(e);
        pushed4++;
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4();
        repeat (2) @(negedge clk);

        // reset lands at E3 while in RUN
        a4 = 4'd10; b4 = 4'd3; sgn4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        check("mid-run reset busy", 32'(busy4), 0);
        check("mid-run reset done", 32'(done4), 0);
        check("mid-run reset q", 32'(q4), 0);
        check("mid-run reset r", 32'(r4), 0);
        check("mid-run reset dz", 32'(dz4), 0);
        rst4 = 1'b0;
        repeat (12) @(negedge clk);
        check("post-reset idle busy", 32'(busy4), 0);

        run8(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0);
        run8(8'h80, 8'd3, 1'b1, 8'hD6, 8'hFE, 1'b0);
        run8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
        run8(8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0);

        repeat (3) @(negedge clk);
        check("dut4 scoreboard drained", sb4.size(), 0);
        check("dut8 scoreboard drained", sb8.size(), 0);
        check("dut4 done count", seen4, pushed4);
        check("dut8 done count", seen8, pushed8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
